alu_regfile_datapath: RTL and testbench

- Execution datapath directly downstream of the sequencing FSMs. Consumes one control word per cycle (regEnable, flagEn, RorI, opcode, Rsrc, Rdest, imm).
- Holds the 16x16-bit register file and the program-status flags; contains the combinational ALU.
- Commits the ALU result to every register selected by regEnable on the rising clock edge.
- Exposes R15 for the 7-segment display and a debug read port.

---
 rtl/alu_regfile_datapath.sv | 158 +++++++++++++++
 tb/tb_alu_regfile_datapath.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_datapath.sv
// Execution datapath: 16x16 register file, ALU and status flags.
// Optional macro REG0_ZERO_EN makes R0 a hardwired zero register.
module alu_regfile_datapath #(
    parameter int          DATA_W  = 16,
    parameter int          NREGS   = 16,
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREGS-1:0]  regEnable,
    input  logic              flagEn,
    input  logic              RorI,
    input  logic [7:0]        opcode,
    input  logic [3:0]        Rsrc,
    input  logic [3:0]        Rdest,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] aluOut,
    output logic [4:0]        flags,
    output logic [DATA_W-1:0] r15,
    input  logic [3:0]        dbgSel,
    output logic [DATA_W-1:0] dbgData
);

    typedef enum logic [3:0] {
        OP_NONE, OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
        OP_AND, OP_OR, OP_XOR, OP_MOV, OP_MUL, OP_LSH, OP_ASHU
    } op_e;

`ifdef REG0_ZERO_EN
    localparam int FIRST_WR = 1;
`else
    localparam int FIRST_WR = 0;
`endif

    logic [DATA_W-1:0] regs [NREGS];

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] idx);
`ifdef REG0_ZERO_EN
        if (idx == 4'd0) return '0;
`endif
        return regs[idx];
    endfunction

    op_e               op;
    logic [DATA_W-1:0] a, b, res;
    logic [DATA_W:0]   sum, dif;
    logic              cin, sub_cin;
    logic [4:0]        amt, namt;
    logic [DATA_W-1:0] shl, lsr, asr;
    logic              fn, fz, ff, fl, fc;

    // Full opcode wins; otherwise the upper nibble names an immediate form
    always_comb begin
        op = OP_NONE;
        case (opcode)
            8'h05: op = OP_ADD;
            8'h06: op = OP_ADDU;
            8'h07: op = OP_ADDC;
            8'h09: op = OP_SUB;
            8'h0A: op = OP_SUBC;
            8'h0B: op = OP_CMP;
            8'h01: op = OP_AND;
            8'h02: op = OP_OR;
            8'h03: op = OP_XOR;
            8'h0D: op = OP_MOV;
            8'h0E: op = OP_MUL;
            8'h88, 8'h80, 8'h81: op = OP_LSH;
            8'h8F, 8'h82, 8'h83: op = OP_ASHU;
            default: begin
                case (opcode[7:4])
                    4'h5: op = OP_ADD;
                    4'h6: op = OP_ADDU;
                    4'h7: op = OP_ADDC;
                    4'h9: op = OP_SUB;
                    4'hA: op = OP_SUBC;
                    4'hB: op = OP_CMP;
                    4'h1: op = OP_AND;
                    4'h2: op = OP_OR;
                    4'h3: op = OP_XOR;
                    4'hD: op = OP_MOV;
                    4'hE: op = OP_MUL;
                    default: op = OP_NONE;
                endcase
            end
        endcase
    end

    assign a = rd(Rdest);
    assign b = RorI ? imm : rd(Rsrc);

    assign cin     = (op == OP_ADDC) && flags[0];
    assign sub_cin = (op == OP_SUBC) && flags[0];

    // Subtraction as A + ~B + 1 - cin; carry-out is the inverted borrow
    assign sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign dif = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, ~sub_cin};

    assign amt  = b[4:0];
    assign namt = 5'd0 - amt;
    assign shl  = a << amt[3:0];
    assign lsr  = a >> namt;
    assign asr  = DATA_W'($signed(a) >>> namt);

    always_comb begin
        res = '0;
        fc  = 1'b0;
        ff  = 1'b0;
        fl  = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                res = sum[DATA_W-1:0];
                fc  = sum[DATA_W];
                ff  = sum[DATA_W] ^ sum[DATA_W-1] ^ a[DATA_W-1] ^ b[DATA_W-1];
            end
            OP_ADDU: begin
                res = sum[DATA_W-1:0];
                fc  = sum[DATA_W];
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                res = dif[DATA_W-1:0];
                fc  = ~dif[DATA_W];
                ff  = dif[DATA_W] ^ dif[DATA_W-1] ^ a[DATA_W-1] ^ ~b[DATA_W-1];
                fl  = a < b;
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MOV:  res = b;
            OP_MUL:  res = a * b;
            OP_LSH:  res = amt[4] ? lsr : shl;
            OP_ASHU: res = amt[4] ? asr : shl;
            default: res = '0;
        endcase
    end

    assign fz = (res == '0);
    assign fn = (op == OP_CMP) ? ($signed(a) < $signed(b)) : res[DATA_W-1];

    assign aluOut  = res;
    assign r15     = rd(4'd15);
    assign dbgData = rd(dbgSel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i < FIRST_WR) ? '0 : RST_VAL;
            flags <= '0;
        end else begin
            if (op != OP_NONE && op != OP_CMP) begin
                for (int i = FIRST_WR; i < NREGS; i++)
                    if (regEnable[i]) regs[i] <= res;
            end
            if (flagEn && op != OP_NONE)
                flags <= {fn, fz, ff, fl, fc};
        end
    end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Randomised and directed bench for alu_regfile_datapath against an
// arithmetic reference model of the register file and flags.
module tb_alu_regfile_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] regEnable = '0;
    logic        flagEn = 1'b0;
    logic        RorI = 1'b0;
    logic [7:0]  opcode = '0;
    logic [3:0]  Rsrc = '0, Rdest = '0, dbgSel = '0;
    logic [15:0] imm = '0;
    logic [15:0] aluOut, r15, dbgData;
    logic [4:0]  flags;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mr [16];
    logic [4:0]  mf;

    alu_regfile_datapath dut (
        .clk(clk), .rst(rst), .regEnable(regEnable), .flagEn(flagEn),
        .RorI(RorI), .opcode(opcode), .Rsrc(Rsrc), .Rdest(Rdest),
        .imm(imm), .aluOut(aluOut), .flags(flags), .r15(r15),
        .dbgSel(dbgSel), .dbgData(dbgData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mread(input int i);
`ifdef REG0_ZERO_EN
        if (i == 0) return 16'h0000;
`endif
        return mr[i];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
        mf = 5'b0;
    endtask

    // 0 none,1 add,2 addu,3 addc,4 sub,5 subc,6 cmp,7 and,8 or,
    // 9 xor,10 mov,11 mul,12 lsh,13 ashu
    function automatic int kind(input logic [7:0] op);
        case (op)
            8'h05: return 1;  8'h06: return 2;  8'h07: return 3;
            8'h09: return 4;  8'h0A: return 5;  8'h0B: return 6;
            8'h01: return 7;  8'h02: return 8;  8'h03: return 9;
            8'h0D: return 10; 8'h0E: return 11;
            8'h88, 8'h80, 8'h81: return 12;
            8'h8F, 8'h82, 8'h83: return 13;
            default: ;
        endcase
        case (op[7:4])
            4'h5: return 1;  4'h6: return 2;  4'h7: return 3;
            4'h9: return 4;  4'hA: return 5;  4'hB: return 6;
            4'h1: return 7;  4'h2: return 8;  4'h3: return 9;
            4'hD: return 10; 4'hE: return 11;
            default: return 0;
        endcase
    endfunction

    task automatic model(input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cf,
                         output logic [15:0] res, output logic [4:0] nf,
                         output bit valid, output bit wr);
        int k;
        longint ua, ub, sa, sb, s, ss, c;
        int sh;
        bit fc, ff, fl, fn;
        k  = kind(op);
        ua = a; ub = b;
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        c  = cf ? 1 : 0;
        fc = 0; ff = 0; fl = 0;
        res = 16'h0000;
        sh = int'(b & 16'h1F);
        if (sh > 15) sh -= 32;
        case (k)
            1, 2, 3: begin
                s  = ua + ub + ((k == 3) ? c : 0);
                ss = sa + sb + ((k == 3) ? c : 0);
                res = 16'(s);
                fc = s > 65535;
                ff = (k != 2) && (ss > 32767 || ss < -32768);
            end
            4, 5, 6: begin
                s  = ua - ub - ((k == 5) ? c : 0);
                ss = sa - sb - ((k == 5) ? c : 0);
                res = 16'(s);
                fc = s < 0;
                ff = ss > 32767 || ss < -32768;
                fl = ua < ub;
            end
            7:  res = a & b;
            8:  res = a | b;
            9:  res = a ^ b;
            10: res = b;
            11: res = 16'(ua * ub);
            12: res = (sh >= 0) ? 16'(ua << sh) : 16'(ua >> (-sh));
            13: res = (sh >= 0) ? 16'(ua << sh) : 16'(sa >>> (-sh));
            default: res = 16'h0000;
        endcase
        fn = (k == 6) ? (sa < sb) : res[15];
        nf = {fn, (k == 6) ? (ua == ub) : (res == 16'h0000), ff, fl, fc};
        valid = (k != 0);
        wr = valid && (k != 6);
    endtask

    task automatic apply(input logic [15:0] re, input logic fe,
                         input logic ri, input logic [7:0] op,
                         input logic [3:0] rs, input logic [3:0] rdst,
                         input logic [15:0] im);
        logic [15:0] a, b, res;
        logic [4:0]  nf;
        bit valid, wr;
        @(negedge clk);
        regEnable = re; flagEn = fe; RorI = ri; opcode = op;
        Rsrc = rs; Rdest = rdst; imm = im;
        dbgSel = 4'($urandom);
        a = mread(rdst);
        b = ri ? im : mread(rs);
        model(op, a, b, mf[0], res, nf, valid, wr);
        #1;
        check("aluOut", aluOut, res);
        check("dbgData", dbgData, mread(dbgSel));
        @(posedge clk);
        if (wr)
            for (int i = 0; i < 16; i++) if (re[i]) mr[i] = res;
        if (fe && valid) mf = nf;
        #1;
        check("flags", flags, mf);
        check("r15", r15, mread(15));
        check("dbgData_post", dbgData, mread(dbgSel));
    endtask

    task automatic peek(input string tag, input logic [3:0] sel,
                        input logic [15:0] exp);
        @(negedge clk);
        regEnable = '0; opcode = 8'h00; dbgSel = sel;
        #1;
        check(tag, dbgData, exp);
    endtask

    logic [7:0] ops [17] = '{8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B,
                             8'h01, 8'h02, 8'h03, 8'h0D, 8'h0E, 8'h88,
                             8'h8F, 8'h80, 8'h81, 8'h82, 8'h83};
    logic [3:0] nibs [11] = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB,
                              4'h1, 4'h2, 4'h3, 4'hD, 4'hE};
    logic [15:0] fib [14] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8,
                              16'd13, 16'd21, 16'd34, 16'd55, 16'd89,
                              16'd144, 16'd233, 16'd377};

    initial begin
        logic [7:0]  op;
        logic [15:0] re;
        mreset();
        #2;
        check("rst_r15", r15, 16'h0000);
        check("rst_flags", flags, 5'b0);
        check("rst_dbg", dbgData, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Fibonacci
        apply(16'h0004, 0, 1, 8'h50, 4'd0, 4'd1, 16'd1);
        for (int n = 2; n <= 14; n++)
            apply(16'(1 << (n + 1)), 0, 0, 8'h05, 4'(n - 1), 4'(n), 16'd0);
        apply(16'h8000, 0, 0, 8'h0D, 4'd15, 4'd0, 16'd0);
        check("fib_r15", r15, 16'h0179);
        for (int i = 2; i <= 15; i++) peek("fib_reg", 4'(i), fib[i - 2]);
        apply(16'h0000, 1, 1, 8'h90, 4'd0, 4'd15, 16'h0200);

        // Asynchronous reset between edges
        @(negedge clk);
        dbgSel = 4'd15;
        regEnable = 16'hFFFF; RorI = 1'b1; opcode = 8'hD0; imm = 16'h5A5A;
        #2 rst = 1'b1;
        #1;
        check("arst_r15", r15, 16'h0000);
        check("arst_dbg", dbgData, 16'h0000);
        check("arst_flags", flags, 5'b0);
        mreset();
        regEnable = '0; opcode = 8'h00;
        #1 rst = 1'b0;

        // Carry chain
        apply(16'h0002, 0, 1, 8'hD0, 4'd0, 4'd0, 16'hFFFF);
        apply(16'h0004, 1, 1, 8'h50, 4'd0, 4'd1, 16'd1);
        check("carry_flags", flags, 5'b01001);
        apply(16'h0008, 1, 0, 8'h07, 4'd2, 4'd2, 16'd0);
        check("addc_flags", flags, 5'b00000);
        peek("addc_r3", 4'd3, 16'h0001);

        // Compare
        apply(16'h0002, 0, 1, 8'hD0, 4'd0, 4'd0, 16'd5);
        apply(16'h0004, 0, 1, 8'hD3, 4'd0, 4'd0, 16'hFFFF);
        apply(16'h0008, 0, 1, 8'hD7, 4'd0, 4'd0, 16'h1234);
        apply(16'h0008, 1, 0, 8'h0B, 4'd2, 4'd1, 16'd0);
        check("cmp_flags", flags, 5'b00011);
        peek("cmp_r3", 4'd3, 16'h1234);

        // Shifts on 8001
        apply(16'h0002, 0, 1, 8'hD0, 4'd0, 4'd0, 16'h8001);
        apply(16'h0010, 0, 1, 8'h80, 4'd0, 4'd1, 16'hFFFF);
        apply(16'h0020, 0, 1, 8'h82, 4'd0, 4'd1, 16'hFFFF);
        apply(16'h0040, 0, 1, 8'hD0, 4'd0, 4'd0, 16'd4);
        apply(16'h0080, 0, 0, 8'h88, 4'd6, 4'd1, 16'd0);
        apply(16'h0100, 0, 1, 8'hD0, 4'd0, 4'd0, 16'hFFF0);
        apply(16'h0200, 0, 0, 8'h88, 4'd8, 4'd1, 16'd0);
        apply(16'h0400, 0, 0, 8'h8F, 4'd8, 4'd1, 16'd0);
        peek("lshi", 4'd4, 16'h4000);
        peek("ashui", 4'd5, 16'hC000);
        peek("lsh4", 4'd7, 16'h0010);
        peek("lsh_m16", 4'd9, 16'h0000);
        peek("ashu_m16", 4'd10, 16'hFFFF);

        // Flags held with flagEn low; multi-register write
        apply(16'h0002, 0, 1, 8'hD0, 4'd0, 4'd0, 16'h7FFF);
        apply(16'h0800, 0, 1, 8'h50, 4'd0, 4'd1, 16'd1);
        peek("noflag_r11", 4'd11, 16'h8000);
        apply(16'h0006, 0, 1, 8'hD0, 4'd0, 4'd0, 16'hABCD);
        peek("multi_r1", 4'd1, 16'hABCD);
        peek("multi_r2", 4'd2, 16'hABCD);
        apply(16'hFFFF, 1, 1, 8'h00, 4'd0, 4'd1, 16'h1111);
        apply(16'hFFFF, 1, 0, 8'h4C, 4'd3, 4'd1, 16'h1111);

`ifdef REG0_ZERO_EN
        apply(16'h0001, 0, 1, 8'hD0, 4'd0, 4'd0, 16'd5);
        peek("r0_zero", 4'd0, 16'h0000);
`endif

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0, 1: op = ops[$urandom_range(0, 16)];
                2: op = {nibs[$urandom_range(0, 10)], 4'($urandom)};
                default: op = 8'($urandom);
            endcase
            re = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15))
                                             : 16'($urandom);
            if ($urandom_range(0, 7) == 0) re = 16'h0000;
            apply(re, 1'($urandom), 1'($urandom), op, 4'($urandom),
                  4'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
